// File: rtl/wc_fifo.sv
// Width-converting FIFO: stores DATA_IN_WIDTH words, returns DATA_OUT_WIDTH chunks LSB first.
// Define WC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module wc_fifo #(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int DEPTH          = 4,
    parameter int AFULL_THRESH   = DEPTH - 1,
    parameter int AEMPTY_THRESH  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_IN_WIDTH-1:0]     din,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic                         flush,
    output logic [DATA_OUT_WIDTH-1:0]    dout,
    output logic                         dout_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   word_count
`ifdef WC_FIFO_ERR_FLAGS_EN
    ,
    output logic                         overflow,
    output logic                         underflow
`endif
);

    localparam int R    = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int CW   = (R > 1) ? $clog2(R) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DATA_IN_WIDTH-1:0]          mem [DEPTH];
    logic [R-1:0][DATA_OUT_WIDTH-1:0]  head;
    logic [AW-1:0]                     wr_ptr, rd_ptr;
    logic [CW-1:0]                     chunk_idx;
    logic                              wr_acc, rd_acc, retire;

    // Flags depend only on the registered count, never on this cycle's requests.
    assign full         = (word_count == CNTW'(DEPTH));
    assign empty        = (word_count == '0);
    assign almost_full  = (word_count >= CNTW'(AFULL_THRESH));
    assign almost_empty = (word_count <= CNTW'(AEMPTY_THRESH));

    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;
    assign retire = rd_acc && (chunk_idx == CW'(R - 1));
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            chunk_idx  <= '0;
            word_count <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            chunk_idx  <= '0;
            word_count <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_acc;
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                dout      <= head[chunk_idx];
                chunk_idx <= retire ? '0 : chunk_idx + 1'b1;
                if (retire)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            // Occupancy moves on whole-word retire, so a partially read word still counts.
            case ({wr_acc, retire})
                2'b10:   word_count <= word_count + 1'b1;
                2'b01:   word_count <= word_count - 1'b1;
                default: word_count <= word_count;
            endcase
        end
    end

`ifdef WC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow <= 1'b1;
            if (rd_en && empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/wc_fifo.md
# wc_fifo

Parametrised width-converting FIFO: stores DATA_IN_WIDTH words and returns them as DATA_OUT_WIDTH chunks, LSB chunk first. It sits in the PE datapath between the wide operand fetch and the narrow MAC input. It is the successor of the PE unpacking FIFO. It adds registered occupancy flags, programmable almost-full/almost-empty thresholds, a synchronous flush, an output valid strobe, and optional sticky error flags.

## Interface
- DATA_IN_WIDTH, 64, write word width; must be an integer multiple R ≥ 1 of DATA_OUT_WIDTH
- DATA_OUT_WIDTH, 16, read chunk width
- DEPTH, 4, storage depth in words; power of two, ≥ 2
- AFULL_THRESH, DEPTH-1, almost_full asserts when word_count ≥ this value
- AEMPTY_THRESH, 1, almost_empty asserts when word_count ≤ this value
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  DATA_IN_WIDTH  write word
- wr_en  in  1  write request
- rd_en  in  1  read request, one chunk per request
- flush  in  1  synchronous clear
- dout  out  DATA_OUT_WIDTH  registered read chunk
- dout_valid  out  1  dout updated this cycle
- full, empty  out  1  occupancy flags
- almost_full, almost_empty  out  1  threshold flags
- word_count  out  $clog2(DEPTH+1)  words held, including a partially read word
- overflow, underflow  out  1  sticky error flags; present only with WC_FIFO_ERR_FLAGS_EN

## Operation
- Reset values: dout=0, dout_valid=0, word_count=0, full=0, almost_full=0, empty=1, almost_empty=1, overflow=0, underflow=0. Pointers and chunk index are 0.
- Write accept: wr_en && !full && !flush. Stores din at wr_ptr. wr_ptr wraps from DEPTH-1 to 0.
- Read accept: rd_en && !empty && !flush.
  - Returns chunk k of the head word, i.e. din[k*DATA_OUT_WIDTH +: DATA_OUT_WIDTH], for k = 0..R-1.
  - k increments on each accepted read.
  - On k = R-1 the head word retires: k returns to 0 and rd_ptr advances, wrapping at DEPTH.
- word_count changes on retire only:
  - +1 on an accepted write without a retire
  - -1 on a retire without an accepted write
  - unchanged when both occur, or when neither occurs
- Flags are functions of the registered word_count: full = (count == DEPTH), empty = (count == 0). No combinational path exists from wr_en or rd_en to any flag.
- Flags and accept decisions use the registered state from the start of the cycle:
  - Write while full, in the same cycle as a retire: the write is dropped.
  - Read while empty, in the same cycle as a write: the read is dropped.
- A rejected read leaves dout unchanged and dout_valid=0.
- flush has priority over wr_en and rd_en. It clears the pointers, the chunk index and word_count. Next cycle: empty=1, dout_valid=0, dout held. Stored data becomes don't-care.
- R = 1: each read retires one word; there is no chunk sequencing.
- Assertion at reset is immediate and asynchronous. Deassertion is taken synchronously by the next clk edge; the integrator synchronises rst_n. Reset in the middle of a word discards the partial chunk state.

## Timing
- Read latency is 1 cycle: an accepted read at edge N gives dout and dout_valid=1 after edge N+1. dout_valid stays high for that one cycle only.
- Back-to-back reads stream one chunk per cycle, including across word boundaries.
- Write-to-read latency is 1 cycle: a word written at edge N clears empty after N+1 and can be read in that cycle.
- A retire or write at edge N updates the flags and word_count after N+1.

## Configuration
- WC_FIFO_ERR_FLAGS_EN defined:
  - overflow sets on wr_en && full && !flush.
  - underflow sets on rd_en && empty && !flush.
  - Both are sticky and are cleared only by rst_n or flush.
- WC_FIFO_ERR_FLAGS_EN undefined: the overflow and underflow ports and their logic are absent. Dropped requests are silent.

## Test plan
- Reset: hold rst_n=0 mid-stream, with no clock edge -> all outputs take their reset values immediately; after release, empty=1 and word_count=0.
- Unpack: write 0x4444_3333_2222_1111, then rd_en for 4 cycles -> dout = 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles with dout_valid=1; empty=1 after the 4th retire; word_count goes 1→0.
- Fill: write 5 words A..E with no reads -> full=1 after the 4th write, almost_full=1 after the 3rd, E dropped, overflow=1 (macro on); readback returns A..D in order.
- Simultaneous at full: set full, chunk index 3, and assert wr_en and rd_en together -> write dropped, retire occurs, word_count=3, full=0.
- Wrap-around: stream 10 words with reads interleaved so that count ≤ 4 -> all 40 chunks arrive in order; no overflow and no underflow.
- Flush mid-word: 2 chunks of word A read, 2 words held; assert flush, then write B -> empty=1 after the flush, and the next reads return B chunk 0 first.
